// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package full_adder_pkg;
  localparam int WIDTH_DEFAULT = 1;
  localparam int MAX_WIDTH     = 64;

  typedef struct packed {
    logic                 carry;
    logic [MAX_WIDTH-1:0] sum;
  } result_t;
endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; ovf exists only with FULL_ADDER_OVF_EN.
interface full_adder_if import full_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (output a, b, c, in_valid, input s, c_out, out_valid, ovf);
  modport slave  (input a, b, c, in_valid, output s, c_out, out_valid, ovf);
`else
  modport master (output a, b, c, in_valid, input s, c_out, out_valid);
  modport slave  (input a, b, c, in_valid, output s, c_out, out_valid);
`endif
endinterface

// File: rtl/full_adder_fa_bit.sv
// Combinational 1-bit full-adder cell; zero latency, no flow control.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple adder; 1-cycle latency, no backpressure (one result per in_valid).
// Optional signed-overflow output enabled by FULL_ADDER_OVF_EN.
module full_adder import full_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  full_adder_if.slave   bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             vld_q;

  assign carry[0] = bus.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_bit (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Result registers only load on accepted operands, so idle inputs never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q <= sum;
        c_q <= carry[WIDTH];
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.c_out     = c_q;
  assign bus.out_valid = vld_q;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1, 8 and 64.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  full_adder_if #(.WIDTH(1))  if1  ();
  full_adder_if #(.WIDTH(8))  if8  ();
  full_adder_if #(.WIDTH(64)) if64 ();

  full_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_adder #(.WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if1.in_valid  = 1'b0;
    if8.in_valid  = 1'b0;
    if64.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]      tbl_sc [8];
  logic [8:0]      exp8;
  logic            expv8;
  logic [1:0]      exp1;
  logic            expv1;
  result_t         exp64;
  logic            expv64;
  logic            expovf8;
  logic [7:0]      ra8;
  logic [7:0]      rb8;
  logic [63:0]     ra64;
  logic [63:0]     rb64;
  logic            rc;
  logic            rv;

  initial begin
    total = 0;
    bad   = 0;
    // (s, c_out) for (a,b,c) = 000..111
    tbl_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    rst_n = 1'b0;
    if1.a = '0;  if1.b = '0;  if1.c = 1'b0;
    if8.a = '0;  if8.b = '0;  if8.c = 1'b0;
    if64.a = '0; if64.b = '0; if64.c = 1'b0;
    idle_all();
    #2;
    chk("reset_s8",   65'(if8.s), 65'h0);
    chk("reset_c8",   65'(if8.c_out), 65'h0);
    chk("reset_v8",   65'(if8.out_valid), 65'h0);
    chk("reset_v1",   65'(if1.out_valid), 65'h0);
`ifdef FULL_ADDER_OVF_EN
    chk("reset_ovf8", 65'(if8.ovf), 65'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if1.a = i[2];
      if1.b = i[1];
      if1.c = i[0];
      if1.in_valid = 1'b1;
      step();
      chk($sformatf("w1_sc_%0d", i), 65'({if1.s, if1.c_out}), 65'(tbl_sc[i]));
      chk($sformatf("w1_v_%0d", i),  65'(if1.out_valid), 65'h1);
    end

    // 1+1+0 then idle with junk on inputs: result must hold
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b0; if1.in_valid = 1'b1;
    step();
    chk("w1_hold_load", 65'({if1.c_out, if1.s}), 65'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if1.in_valid = 1'b0;
      if1.a = 1'($urandom);
      if1.b = 1'($urandom);
      if1.c = 1'($urandom);
      if (i == 1) begin
        if1.a = 1'bx; if1.b = 1'bz; if1.c = 1'bx;
      end
      step();
      chk($sformatf("w1_hold_sc_%0d", i), 65'({if1.c_out, if1.s}), 65'b10);
      chk($sformatf("w1_hold_v_%0d", i),  65'(if1.out_valid), 65'h0);
    end

    // 8-bit wrap-around and ordinary sums, back to back
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1; if8.in_valid = 1'b1;
    step();
    chk("w8_ff_ff_1", 65'({if8.c_out, if8.s}), 65'h1FF);
    chk("w8_ff_ff_1_v", 65'(if8.out_valid), 65'h1);
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'h00; if8.c = 1'b1;
    step();
    chk("w8_ff_00_1", 65'({if8.c_out, if8.s}), 65'h100);
    chk("w8_ff_00_1_v", 65'(if8.out_valid), 65'h1);
    @(negedge clk);
    if8.a = 8'h12; if8.b = 8'h34; if8.c = 1'b0;
    step();
    chk("w8_12_34_0", 65'({if8.c_out, if8.s}), 65'h046);
    @(negedge clk);
    if8.a = 8'hA5; if8.b = 8'h5A; if8.c = 1'b1;
    step();
    chk("w8_a5_5a_1", 65'({if8.c_out, if8.s}), 65'h100);
`ifdef FULL_ADDER_OVF_EN
    @(negedge clk);
    if8.a = 8'h7F; if8.b = 8'h01; if8.c = 1'b0;
    step();
    chk("ovf_7f_01", 65'({if8.ovf, if8.c_out, if8.s}), 65'h280);
    @(negedge clk);
    if8.a = 8'h80; if8.b = 8'h80; if8.c = 1'b0;
    step();
    chk("ovf_80_80", 65'({if8.ovf, if8.c_out, if8.s}), 65'h300);
    @(negedge clk);
    if8.a = 8'h01; if8.b = 8'h01; if8.c = 1'b0;
    step();
    chk("ovf_01_01", 65'({if8.ovf, if8.c_out, if8.s}), 65'h002);
`endif

    // Mid-stream asynchronous reset
    @(negedge clk);
    if8.a = 8'h01; if8.b = 8'h00; if8.c = 1'b0; if8.in_valid = 1'b1;
    step();
    chk("rst_pre_s", 65'(if8.s), 65'h1);
    chk("rst_pre_v", 65'(if8.out_valid), 65'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_s", 65'(if8.s), 65'h0);
    chk("rst_async_c", 65'(if8.c_out), 65'h0);
    chk("rst_async_v", 65'(if8.out_valid), 65'h0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst_nopulse_%0d", i), 65'(if8.out_valid), 65'h0);
      chk($sformatf("rst_nodata_%0d", i),  65'(if8.s), 65'h0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if8.a = 8'h03; if8.b = 8'h04; if8.c = 1'b0; if8.in_valid = 1'b1;
    step();
    chk("rst_first_edge_s", 65'({if8.c_out, if8.s}), 65'h007);
    chk("rst_first_edge_v", 65'(if8.out_valid), 65'h1);

    // Clean start for the random run
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp1 = '0; exp8 = '0; exp64 = '0; expovf8 = 1'b0;

    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 7) != 0);
      rc = 1'($urandom);
      if1.a = 1'($urandom); if1.b = 1'($urandom); if1.c = rc; if1.in_valid = rv;
      if (rv) exp1 = 2'({1'b0, if1.a} + {1'b0, if1.b} + {1'b0, rc});
      expv1 = rv;

      rv = ($urandom_range(0, 7) != 0);
      rc = 1'($urandom);
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      if8.a = ra8; if8.b = rb8; if8.c = rc; if8.in_valid = rv;
      if (rv) begin
        exp8 = {1'b0, ra8} + {1'b0, rb8} + {8'h00, rc};
        expovf8 = (ra8[7] == rb8[7]) && (exp8[7] != ra8[7]);
      end
      expv8 = rv;

      rv = ($urandom_range(0, 7) != 0);
      rc = 1'($urandom);
      ra64 = {$urandom, $urandom}; rb64 = {$urandom, $urandom};
      if (n < 8) begin
        ra64 = '1;
        rb64 = (n[0]) ? '1 : '0;
      end
      if64.a = ra64; if64.b = rb64; if64.c = rc; if64.in_valid = rv;
      if (rv) exp64 = {1'b0, ra64} + {1'b0, rb64} + {64'h0, rc};
      expv64 = rv;

      step();
      chk("rnd_w1",    65'({if1.c_out, if1.s}), 65'(exp1));
      chk("rnd_w1_v",  65'(if1.out_valid), 65'(expv1));
      chk("rnd_w8",    65'({if8.c_out, if8.s}), 65'(exp8));
      chk("rnd_w8_v",  65'(if8.out_valid), 65'(expv8));
      chk("rnd_w64",   {if64.c_out, if64.s}, exp64);
      chk("rnd_w64_v", 65'(if64.out_valid), 65'(expv64));
`ifdef FULL_ADDER_OVF_EN
      chk("rnd_w8_ovf", 65'(if8.ovf), 65'(expovf8));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, 1, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock, no other clock domains.
REQ-004 a  input  WIDTH  addend A, unsigned.
REQ-005 b  input  WIDTH  addend B, unsigned.
REQ-006 c  input  1  carry-in.
REQ-007 in_valid  input  1  qualifies a/b/c for the current cycle.
REQ-008 s  output  WIDTH  registered sum.
REQ-009 c_out  output  1  registered carry-out.
REQ-010 out_valid  output  1  high for exactly one cycle per accepted operand set.

Function
REQ-011 {c_out, s} SHALL equal a + b + c computed at WIDTH+1 bits; no truncation before carry extraction.
REQ-012 For WIDTH=1: s = a^b^c and c_out = (a&b)|(a&c)|(b&c).
REQ-013 Operands SHALL be sampled on a rising clk edge when in_valid=1; s, c_out and out_valid SHALL update at that same edge (latency 1 cycle from sample to visible result).
REQ-014 Edge with in_valid=0: s and c_out hold their last values; out_valid=0.
REQ-015 Back-to-back in_valid=1 SHALL give one result per cycle with no bubbles; no backpressure input exists.
REQ-016 Wrap-around: all-ones + all-ones + 1 SHALL give s = all-ones, c_out=1; all-ones + 0 + 1 SHALL give s=0, c_out=1.
REQ-017 Carry chain: ripple of WIDTH bit cells, bit 0 fed by c, carry of bit i feeds bit i+1, carry of bit WIDTH-1 is c_out.
REQ-018 X/Z on inputs while in_valid=0 SHALL NOT affect any output.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock edge, force s=0, c_out=0, out_valid=0 (and ovf=0 when present).
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; no out_valid pulse after release until a new in_valid=1 edge.
REQ-021 Reset deassertion synchronous to clk is the integrator's responsibility; the first edge with rst_n=1 and in_valid=1 SHALL be accepted.

Configuration
REQ-022 Macro FULL_ADDER_OVF_EN: when defined, the module SHALL add output ovf (1 bit, registered with s) = signed overflow, i.e. carry into MSB XOR carry out of MSB.
REQ-023 Without FULL_ADDER_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-024 Package full_adder_pkg SHALL hold the WIDTH default constant, the maximum-width constant (64) and a result struct type {carry, sum}.
REQ-025 One sub-module fa_bit SHALL implement the purely combinational 1-bit cell (a, b, cin -> s, cout), instantiated WIDTH times via generate.
REQ-026 All sequential logic SHALL live in full_adder; fa_bit has no clock or reset.

Verification
REQ-027 WIDTH=1, in_valid=1, drive (a,b,c) through 000..111, one per cycle -> (s,c_out) = 00,10,10,01,10,01,01,11, each one cycle after its edge, out_valid=1 throughout.
REQ-028 WIDTH=8, a=8'hFF, b=8'hFF, c=1 -> s=8'hFF, c_out=1; a=8'hFF, b=0, c=1 -> s=0, c_out=1.
REQ-029 in_valid=1 with a=1,b=1,c=0, then in_valid=0 for 3 cycles with random a/b/c -> s=0, c_out=1 held, out_valid=0 during the idle cycles.
REQ-030 Assert rst_n=0 between clock edges after a result s=1 -> s, c_out, out_valid fall to 0 immediately; no pulse after release until new in_valid.
REQ-031 FULL_ADDER_OVF_EN, WIDTH=8: a=8'h7F, b=8'h01, c=0 -> s=8'h80, c_out=0, ovf=1; a=8'h80, b=8'h80, c=0 -> s=0, c_out=1, ovf=1.
REQ-032 Random 10k vectors at WIDTH=1, 8 and 64 against the a+b+c reference model -> zero mismatches.
